// File: rtl/reg_scoreboard_if.sv
// reg_scoreboard_if
// Decode/writeback to scoreboard bundle.
//   master : decode + writeback side; drives the issue_*, flush and wb_* signals
//            and reads stall, forwarding, busy_mask and stall_count.
//   slave  : the scoreboard itself.
interface reg_scoreboard_if #(
    parameter int NREGS  = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 3,
    parameter int PERF_W = 32
);
    logic              issue_valid;
    logic [REG_W-1:0]  issue_rs;
    logic [REG_W-1:0]  issue_rt;
    logic              issue_uses_rs;
    logic              issue_uses_rt;
    logic              issue_wen;
    logic [REG_W-1:0]  issue_rd;
    logic [CNT_W-1:0]  issue_lat;
    logic              flush;
    logic              wb_valid;
    logic [REG_W-1:0]  wb_rd;
    logic              stall;
    logic              fwd_rs;
    logic              fwd_rt;
    logic [NREGS-1:0]  busy_mask;
    logic [PERF_W-1:0] stall_count;

    modport master (
        output issue_valid, issue_rs, issue_rt, issue_uses_rs, issue_uses_rt,
               issue_wen, issue_rd, issue_lat, flush, wb_valid, wb_rd,
        input  stall, fwd_rs, fwd_rt, busy_mask, stall_count
    );

    modport slave (
        input  issue_valid, issue_rs, issue_rt, issue_uses_rs, issue_uses_rt,
               issue_wen, issue_rd, issue_lat, flush, wb_valid, wb_rd,
        output stall, fwd_rs, fwd_rt, busy_mask, stall_count
    );
endinterface

// File: rtl/reg_scoreboard.sv
// reg_scoreboard
// Register-hazard scoreboard for the decode stage. Each architectural register
// carries a pending bit and a countdown of cycles until its in-flight result
// can be forwarded. Decode stalls on RAW/WAW against a register whose count
// is still non-zero; once the count reaches zero the operand is flagged as
// forwardable instead.
// Ports:
//   CLK, RST : clock, synchronous active-high reset
//   sb       : reg_scoreboard_if.slave (issue/flush/writeback in,
//              stall/fwd_rs/fwd_rt/busy_mask/stall_count out)
module reg_scoreboard #(
    parameter int NREGS  = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 3,
    parameter int PERF_W = 32
) (
    input  logic            CLK,
    input  logic            RST,
    reg_scoreboard_if.slave sb
);
    logic [NREGS-1:0]            r_pending;
    logic [NREGS-1:0][CNT_W-1:0] r_cnt;
    logic [PERF_W-1:0]           r_stall_count;

    logic w_raw_rs, w_raw_rt, w_waw, w_stall, w_accept;
    logic w_rs_nz, w_rt_nz, w_rd_nz;

    assign w_rs_nz = (sb.issue_rs != '0);
    assign w_rt_nz = (sb.issue_rt != '0);
    assign w_rd_nz = (sb.issue_rd != '0);

    // A pending register with a non-zero count has no forwardable result yet.
    assign w_raw_rs = sb.issue_uses_rs & w_rs_nz & r_pending[sb.issue_rs] & (r_cnt[sb.issue_rs] != '0);
    assign w_raw_rt = sb.issue_uses_rt & w_rt_nz & r_pending[sb.issue_rt] & (r_cnt[sb.issue_rt] != '0);
    assign w_waw    = sb.issue_wen     & w_rd_nz & r_pending[sb.issue_rd] & (r_cnt[sb.issue_rd] != '0);

    assign w_stall  = sb.issue_valid & ~sb.flush & (w_raw_rs | w_raw_rt | w_waw);
    assign w_accept = sb.issue_valid & ~w_stall & ~sb.flush;

    // Forwarding flags ignore issue_valid so the bypass muxes can be set up early.
    assign sb.fwd_rs = sb.issue_uses_rs & w_rs_nz & r_pending[sb.issue_rs] & (r_cnt[sb.issue_rs] == '0);
    assign sb.fwd_rt = sb.issue_uses_rt & w_rt_nz & r_pending[sb.issue_rt] & (r_cnt[sb.issue_rt] == '0);

    assign sb.stall       = w_stall;
    assign sb.busy_mask   = r_pending;
    assign sb.stall_count = r_stall_count;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pending     <= '0;
            r_cnt         <= '0;
            r_stall_count <= '0;
        end else begin
            // r0 is hardwired zero and never tracked.
            r_pending[0] <= 1'b0;
            r_cnt[0]     <= '0;
            for (int r = 1; r < NREGS; r++) begin
                // New issue wins over a same-cycle writeback: the writeback
                // belongs to the older producer being replaced.
                if (w_accept && sb.issue_wen && sb.issue_rd == REG_W'(r)) begin
                    r_pending[r] <= 1'b1;
                    r_cnt[r]     <= sb.issue_lat;
                end else if (sb.wb_valid && sb.wb_rd == REG_W'(r)) begin
                    r_pending[r] <= 1'b0;
                    r_cnt[r]     <= '0;
                end else if (r_cnt[r] != '0) begin
                    r_cnt[r] <= r_cnt[r] - 1'b1;
                end
            end
            if (w_stall && (r_stall_count != {PERF_W{1'b1}}))
                r_stall_count <= r_stall_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard
// Directed bench for reg_scoreboard. Two instances receive identical stimulus:
// u_dut (PERF_W=32) and u_sat (PERF_W=4, exercises stall counter saturation).
module tb_reg_scoreboard;
    logic CLK = 1'b0;
    logic RST;
    int   n_pass = 0;
    int   n_tot  = 0;

    always #5 CLK = ~CLK;

    reg_scoreboard_if #(.PERF_W(32)) sb_a ();
    reg_scoreboard_if #(.PERF_W(4))  sb_b ();

    // Mirror the stimulus of the main instance onto the saturating one.
    assign sb_b.issue_valid   = sb_a.issue_valid;
    assign sb_b.issue_rs      = sb_a.issue_rs;
    assign sb_b.issue_rt      = sb_a.issue_rt;
    assign sb_b.issue_uses_rs = sb_a.issue_uses_rs;
    assign sb_b.issue_uses_rt = sb_a.issue_uses_rt;
    assign sb_b.issue_wen     = sb_a.issue_wen;
    assign sb_b.issue_rd      = sb_a.issue_rd;
    assign sb_b.issue_lat     = sb_a.issue_lat;
    assign sb_b.flush         = sb_a.flush;
    assign sb_b.wb_valid      = sb_a.wb_valid;
    assign sb_b.wb_rd         = sb_a.wb_rd;

    reg_scoreboard #(.PERF_W(32)) u_dut (.CLK(CLK), .RST(RST), .sb(sb_a.slave));
    reg_scoreboard #(.PERF_W(4))  u_sat (.CLK(CLK), .RST(RST), .sb(sb_b.slave));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance one edge; inputs change 1 time unit after it.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #2;
    endtask

    task automatic idle();
        sb_a.issue_valid   = 1'b0;
        sb_a.issue_rs      = '0;
        sb_a.issue_rt      = '0;
        sb_a.issue_uses_rs = 1'b0;
        sb_a.issue_uses_rt = 1'b0;
        sb_a.issue_wen     = 1'b0;
        sb_a.issue_rd      = '0;
        sb_a.issue_lat     = '0;
        sb_a.flush         = 1'b0;
        sb_a.wb_valid      = 1'b0;
        sb_a.wb_rd         = '0;
    endtask

    task automatic do_reset();
        idle();
        RST = 1'b1;
        step();
        RST = 1'b0;
    endtask

    task automatic producer(input logic [4:0] rd, input logic [2:0] lat);
        idle();
        sb_a.issue_valid = 1'b1;
        sb_a.issue_wen   = 1'b1;
        sb_a.issue_rd    = rd;
        sb_a.issue_lat   = lat;
    endtask

    task automatic consumer_rs(input logic [4:0] rs);
        idle();
        sb_a.issue_valid   = 1'b1;
        sb_a.issue_uses_rs = 1'b1;
        sb_a.issue_rs      = rs;
    endtask

    initial begin
        // Reset overrides an accepted-looking write to r5.
        producer(5'd5, 3'd2);
        RST = 1'b1;
        step();
        RST = 1'b0;
        idle();
        settle();
        chk("rst_stall", 64'(sb_a.stall), 64'd0);
        chk("rst_busy", 64'(sb_a.busy_mask), 64'd0);
        chk("rst_cnt", 64'(sb_a.stall_count), 64'd0);
        chk("rst_fwd", 64'({sb_a.fwd_rs, sb_a.fwd_rt}), 64'd0);

        // RAW against a load with latency 2: two stall cycles, then forward.
        producer(5'd8, 3'd2);
        settle();
        chk("raw_prod_stall", 64'(sb_a.stall), 64'd0);
        step();
        consumer_rs(5'd8);
        settle();
        chk("raw_busy8", 64'(sb_a.busy_mask[8]), 64'd1);
        chk("raw_stall_c1", 64'(sb_a.stall), 64'd1);
        chk("raw_fwd_c1", 64'(sb_a.fwd_rs), 64'd0);
        step();
        settle();
        chk("raw_stall_c2", 64'(sb_a.stall), 64'd1);
        step();
        settle();
        chk("raw_stall_c3", 64'(sb_a.stall), 64'd0);
        chk("raw_fwd_c3", 64'(sb_a.fwd_rs), 64'd1);
        step();
        idle();
        settle();
        chk("raw_count", 64'(sb_a.stall_count), 64'd2);

        // Zero-latency ALU producer: forwardable next cycle, cleared by writeback.
        do_reset();
        producer(5'd3, 3'd0);
        step();
        consumer_rs(5'd3);
        sb_a.issue_uses_rt = 1'b1;
        sb_a.issue_rt      = 5'd3;
        settle();
        chk("alu_stall", 64'(sb_a.stall), 64'd0);
        chk("alu_fwd_rs", 64'(sb_a.fwd_rs), 64'd1);
        chk("alu_fwd_rt", 64'(sb_a.fwd_rt), 64'd1);
        sb_a.issue_valid = 1'b0;
        settle();
        chk("alu_fwd_novalid", 64'(sb_a.fwd_rs), 64'd1);
        chk("alu_busy3", 64'(sb_a.busy_mask), 64'h8);
        idle();
        sb_a.wb_valid = 1'b1;
        sb_a.wb_rd    = 5'd3;
        step();
        idle();
        settle();
        chk("alu_wb_clear", 64'(sb_a.busy_mask), 64'd0);

        // r0 is never tracked; a flushed producer never lands.
        do_reset();
        producer(5'd0, 3'd3);
        step();
        idle();
        settle();
        chk("r0_busy", 64'(sb_a.busy_mask), 64'd0);
        producer(5'd9, 3'd3);
        sb_a.flush = 1'b1;
        settle();
        chk("flush_stall", 64'(sb_a.stall), 64'd0);
        step();
        idle();
        settle();
        chk("flush_busy", 64'(sb_a.busy_mask), 64'd0);
        producer(5'd9, 3'd3);
        step();
        consumer_rs(5'd9);
        sb_a.flush = 1'b1;
        settle();
        chk("flush_hides_raw", 64'(sb_a.stall), 64'd0);
        sb_a.flush = 1'b0;
        settle();
        chk("raw_after_flush", 64'(sb_a.stall), 64'd1);

        // Same-cycle issue and writeback to r4: issue wins; then WAW for one cycle.
        do_reset();
        producer(5'd4, 3'd1);
        sb_a.wb_valid = 1'b1;
        sb_a.wb_rd    = 5'd4;
        step();
        producer(5'd4, 3'd0);
        settle();
        chk("iwb_busy4", 64'(sb_a.busy_mask), 64'h10);
        chk("waw_stall_c1", 64'(sb_a.stall), 64'd1);
        step();
        settle();
        chk("waw_stall_c2", 64'(sb_a.stall), 64'd0);
        step();
        idle();
        settle();
        chk("waw_count", 64'(sb_a.stall_count), 64'd1);

        // Three rounds of a 7-cycle RAW give 21 stalled cycles; 4-bit counter stops at 15.
        do_reset();
        for (int rnd = 0; rnd < 3; rnd++) begin
            producer(5'd10, 3'd7);
            step();
            consumer_rs(5'd10);
            for (int c = 0; c < 7; c++) begin
                settle();
                chk($sformatf("sat_stall_r%0d_c%0d", rnd, c), 64'(sb_a.stall), 64'd1);
                step();
            end
            settle();
            chk($sformatf("sat_release_r%0d", rnd), 64'(sb_a.stall), 64'd0);
            step();
            idle();
            settle();
            if (rnd == 0) chk("sat_small_cnt", 64'(sb_b.stall_count), 64'd7);
        end
        chk("sat_wide_cnt", 64'(sb_a.stall_count), 64'd21);
        chk("sat_narrow_cnt", 64'(sb_b.stall_count), 64'd15);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
